dsp_mode_sequencer: RTL and testbench

Sample-rate controller that sequences mode changes of the DSP subsystem (dry / FIR / echo selector) without audible clicks. It qualifies a requested mode from the user switches for a hold period, then fades the processed output to silence, switches the selector, and fades back up. It sits between the switch inputs and the DSP subsystem: it drives the subsystem's selector and scales the subsystem's output sample before the codec.

---
 rtl/dsp_ctrl_pkg.sv | 26 ++
 rtl/gain_scaler.sv | 34 +++
 rtl/dsp_mode_sequencer.sv | 123 ++++++++++++
 tb/tb_dsp_mode_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the DSP mode sequencer: mode codes, sequencer
// state encoding and small decode helpers.
package dsp_ctrl_pkg;

   localparam logic [1:0] MODE_DRY  = 2'b00;
   localparam logic [1:0] MODE_FIR  = 2'b01;
   localparam logic [1:0] MODE_ECHO = 2'b10;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      QUALIFY  = 3'd1,
      FADE_OUT = 3'd2,
      SWITCH   = 3'd3,
      FADE_IN  = 3'd4
   } seq_state_t;

   // The unused switch code 11 selects the dry path.
   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      return (m == 2'b11) ? MODE_DRY : m;
   endfunction

   function automatic logic is_busy(input seq_state_t s);
      return (s == FADE_OUT) || (s == SWITCH) || (s == FADE_IN);
   endfunction

endpackage

// File: rtl/gain_scaler.sv
// Registered signed sample scaler: out = (sample * gain) >>> RAMP_LOG2,
// floor rounding, truncated to 16 bits.
module gain_scaler #(
   parameter int RAMP_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic signed [15:0]    sample,
   input  logic [RAMP_LOG2:0]    gain,
   output logic signed [15:0]    scaled
);

   localparam int PW = 16 + RAMP_LOG2 + 2;

   logic signed [RAMP_LOG2+1:0] gain_s;
   logic signed [PW-1:0]        sample_ext;
   logic signed [PW-1:0]        gain_ext;
   logic signed [PW-1:0]        product;

   // Gain is unsigned; a zero sign bit keeps the multiply fully signed.
   assign gain_s     = $signed({1'b0, gain});
   assign sample_ext = PW'(sample);
   assign gain_ext   = PW'(gain_s);
   assign product    = sample_ext * gain_ext;

   always_ff @(posedge clk) begin
      if (reset) begin
         scaled <= '0;
      end else begin
         scaled <= 16'(product >>> RAMP_LOG2);
      end
   end

endmodule

// File: rtl/dsp_mode_sequencer.sv
// Click-free mode sequencer: qualifies a switch request, fades the DSP output
// to silence, changes the selector, then fades back up.
module dsp_mode_sequencer #(
   parameter int RAMP_LOG2 = 6,
   parameter int HOLD      = 16
) (
   input  logic               sample_clock,
   input  logic               reset,
   input  logic [1:0]         req_mode,
   input  logic signed [15:0] dsp_sample,
   output logic [1:0]         selector,
   output logic signed [15:0] out_sample,
   output logic               busy,
   output logic               mode_changed
);

   import dsp_ctrl_pkg::*;

   localparam int GW  = RAMP_LOG2 + 1;
   localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [GW-1:0]  GAIN_FULL = GW'(1 << RAMP_LOG2);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);

   seq_state_t     state, state_n;
   logic [1:0]     req_n;
   logic [1:0]     candidate, candidate_n;
   logic [1:0]     target, target_n;
   logic [1:0]     selector_n;
   logic [HCW-1:0] hold_cnt, hold_cnt_n;
   logic [GW-1:0]  gain, gain_n;
   logic           mode_changed_n;

   assign req_n = norm_mode(req_mode);

   always_ff @(posedge sample_clock) begin
      if (reset) begin
         state        <= IDLE;
         candidate    <= MODE_DRY;
         target       <= MODE_DRY;
         selector     <= MODE_DRY;
         hold_cnt     <= '0;
         gain         <= GAIN_FULL;
         busy         <= 1'b0;
         mode_changed <= 1'b0;
      end else begin
         state        <= state_n;
         candidate    <= candidate_n;
         target       <= target_n;
         selector     <= selector_n;
         hold_cnt     <= hold_cnt_n;
         gain         <= gain_n;
         busy         <= is_busy(state_n);
         mode_changed <= mode_changed_n;
      end
   end

   always_comb begin
      state_n        = state;
      candidate_n    = candidate;
      target_n       = target;
      selector_n     = selector;
      hold_cnt_n     = hold_cnt;
      gain_n         = gain;
      mode_changed_n = 1'b0;
      case (state)
         IDLE: begin
            gain_n = GAIN_FULL;
            if (req_n != selector) begin
               state_n     = QUALIFY;
               candidate_n = req_n;
               hold_cnt_n  = '0;
            end
         end
         QUALIFY: begin
            gain_n = GAIN_FULL;
            if (req_n == selector) begin
               state_n = IDLE;
            end else if (req_n != candidate) begin
               // A different request restarts the stability window.
               candidate_n = req_n;
               hold_cnt_n  = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               target_n = candidate;
               state_n  = FADE_OUT;
            end else begin
               hold_cnt_n = hold_cnt + HCW'(1);
            end
         end
         FADE_OUT: begin
            gain_n = gain - GW'(1);
            if (gain == GW'(1)) begin
               state_n = SWITCH;
            end
         end
         SWITCH: begin
            gain_n         = '0;
            selector_n     = target;
            mode_changed_n = 1'b1;
            state_n        = FADE_IN;
         end
         FADE_IN: begin
            gain_n = gain + GW'(1);
            if (gain == GAIN_FULL - GW'(1)) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   gain_scaler #(
      .RAMP_LOG2(RAMP_LOG2)
   ) u_gain_scaler (
      .clk    (sample_clock),
      .reset  (reset),
      .sample (dsp_sample),
      .gain   (gain),
      .scaled (out_sample)
   );

endmodule

// File: tb/tb_dsp_mode_sequencer.sv
// Directed bench for dsp_mode_sequencer: reset, pass-through, qualification,
// fade timing and arithmetic, request changes during ramps, mid-ramp reset.
module tb_dsp_mode_sequencer;

   logic               sample_clock;
   logic               reset;
   logic [1:0]         req_mode;
   logic signed [15:0] dsp_sample;
   logic [1:0]         selector;
   logic signed [15:0] out_sample;
   logic               busy;
   logic               mode_changed;

   int total = 0;
   int bad   = 0;

   dsp_mode_sequencer #(
      .RAMP_LOG2(6),
      .HOLD     (16)
   ) dut (
      .sample_clock (sample_clock),
      .reset        (reset),
      .req_mode     (req_mode),
      .dsp_sample   (dsp_sample),
      .selector     (selector),
      .out_sample   (out_sample),
      .busy         (busy),
      .mode_changed (mode_changed)
   );

   // clock / reset
   initial sample_clock = 1'b0;
   always #5 sample_clock = ~sample_clock;

   task automatic tick();
      @(posedge sample_clock);
      #1;
   endtask

   // Runs until busy falls after having risen; n counts edges from the call.
   task automatic watch(input int budget, input int chg_at, input logic [1:0] chg_val,
                        output int rise_at, output int mc_at, output int mc_cnt,
                        output logic [1:0] sel_mc, output int busy_cycles, output int fall_at);
      rise_at = -1; mc_at = -1; mc_cnt = 0; sel_mc = 2'b00; busy_cycles = 0; fall_at = -1;
      for (int n = 1; n <= budget; n++) begin
         tick();
         if (busy) busy_cycles++;
         if (busy && rise_at < 0) rise_at = n;
         if (!busy && rise_at >= 0 && fall_at < 0) fall_at = n;
         if (mode_changed) begin
            mc_cnt++;
            if (mc_at < 0) begin
               mc_at  = n;
               sel_mc = selector;
            end
         end
         if (n == chg_at) req_mode = chg_val;
         if (fall_at >= 0) break;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_mode = 2'b00; dsp_sample = 16'sd1000;
      repeat (3) tick();
      total++;
      if (selector !== 2'b00 || busy !== 1'b0 || mode_changed !== 1'b0 || out_sample !== 16'sd0) begin
         bad++;
         $display("FAIL reset_state: sel=%0d busy=%0b mc=%0b out=%0d required sel=0 busy=0 mc=0 out=0",
                  selector, busy, mode_changed, out_sample);
      end
      reset = 1'b0;
      tick();
      total++;
      if (out_sample !== 16'sd1000) begin
         bad++;
         $display("FAIL reset_release_out: out=%0d required 1000", out_sample);
      end
   endtask

   task automatic test_idle();
      logic signed [15:0] vec [4];
      int busy_seen = 0, mc_seen = 0;
      vec[0] = 16'sd1000; vec[1] = -16'sd32768; vec[2] = 16'sd32767; vec[3] = -16'sd1;
      for (int i = 0; i < 4; i++) begin
         dsp_sample = vec[i];
         tick();
         if (busy) busy_seen++;
         if (mode_changed) mc_seen++;
         total++;
         if (out_sample !== vec[i]) begin
            bad++;
            $display("FAIL idle_passthru[%0d]: out=%0d required %0d", i, out_sample, vec[i]);
         end
      end
      repeat (8) begin
         tick();
         if (busy) busy_seen++;
         if (mode_changed) mc_seen++;
      end
      total++;
      if (busy_seen != 0 || mc_seen != 0 || selector !== 2'b00) begin
         bad++;
         $display("FAIL idle_quiet: busy_cycles=%0d pulses=%0d sel=%0d required 0 0 0",
                  busy_seen, mc_seen, selector);
      end
      dsp_sample = 16'sd1000;
   endtask

   task automatic test_glitch();
      int busy_seen = 0, mc_seen = 0;
      req_mode = 2'b10;
      repeat (5) begin
         tick();
         if (busy) busy_seen++;
         if (mode_changed) mc_seen++;
      end
      req_mode = 2'b00;
      repeat (40) begin
         tick();
         if (busy) busy_seen++;
         if (mode_changed) mc_seen++;
      end
      total++;
      if (busy_seen != 0 || mc_seen != 0 || selector !== 2'b00) begin
         bad++;
         $display("FAIL glitch_rejected: busy_cycles=%0d pulses=%0d sel=%0d required 0 0 0",
                  busy_seen, mc_seen, selector);
      end
   endtask

   task automatic test_hold_restart();
      int rise_at, mc_at, mc_cnt, busy_cycles, fall_at;
      logic [1:0] sel_mc;
      int early_busy = 0;
      req_mode = 2'b10;
      repeat (10) begin
         tick();
         if (busy) early_busy++;
      end
      req_mode = 2'b01;
      watch(400, -1, 2'b00, rise_at, mc_at, mc_cnt, sel_mc, busy_cycles, fall_at);
      total++;
      if (early_busy != 0 || rise_at != 17) begin
         bad++;
         $display("FAIL hold_restart_latency: early_busy=%0d rise_at=%0d required 0 17", early_busy, rise_at);
      end
      total++;
      if (fall_at < 0 || mc_cnt != 1 || sel_mc !== 2'b01 || selector !== 2'b01) begin
         bad++;
         $display("FAIL hold_restart_final: fall_at=%0d pulses=%0d sel_at_pulse=%0d sel=%0d required done 1 1 1",
                  fall_at, mc_cnt, sel_mc, selector);
      end
   endtask

   task automatic test_map_11_and_requeue();
      int rise_at, mc_at, mc_cnt, busy_cycles, fall_at;
      logic [1:0] sel_mc;
      req_mode = 2'b11;
      // req goes to 10 at n=97, inside FADE_IN (n=82..145)
      watch(400, 97, 2'b10, rise_at, mc_at, mc_cnt, sel_mc, busy_cycles, fall_at);
      total++;
      if (rise_at != 17 || mc_at - rise_at != 65 || busy_cycles != 129 || fall_at != 146) begin
         bad++;
         $display("FAIL map11_timing: rise=%0d mc_delta=%0d busy=%0d fall=%0d required 17 65 129 146",
                  rise_at, mc_at - rise_at, busy_cycles, fall_at);
      end
      total++;
      if (mc_cnt != 1 || sel_mc !== 2'b00 || selector !== 2'b00) begin
         bad++;
         $display("FAIL map11_select: pulses=%0d sel_at_pulse=%0d sel=%0d required 1 0 0",
                  mc_cnt, sel_mc, selector);
      end
      watch(400, -1, 2'b00, rise_at, mc_at, mc_cnt, sel_mc, busy_cycles, fall_at);
      total++;
      if (rise_at != 17 || fall_at < 0 || sel_mc !== 2'b10 || selector !== 2'b10) begin
         bad++;
         $display("FAIL requeue_echo: rise=%0d fall=%0d sel_at_pulse=%0d sel=%0d required 17 done 2 2",
                  rise_at, fall_at, sel_mc, selector);
      end
   endtask

   task automatic test_reset_mid_fade();
      logic signed [15:0] exp_v;
      dsp_sample = 16'sd1000;
      req_mode = 2'b00;
      // busy rises at edge 17 with gain 64; gain 20 after 44 more edges
      repeat (61) tick();
      total++;
      if (busy !== 1'b1 || out_sample !== 16'sd328) begin
         bad++;
         $display("FAIL pre_reset_ramp: busy=%0b out=%0d required 1 328", busy, out_sample);
      end
      reset = 1'b1;
      tick();
      total++;
      if (selector !== 2'b00 || busy !== 1'b0 || mode_changed !== 1'b0 || out_sample !== 16'sd0) begin
         bad++;
         $display("FAIL mid_fade_reset: sel=%0d busy=%0b mc=%0b out=%0d required 0 0 0 0",
                  selector, busy, mode_changed, out_sample);
      end
      reset = 1'b0;
      dsp_sample = 16'sd1234;
      tick();
      total++;
      if (out_sample !== 16'sd1234) begin
         bad++;
         $display("FAIL post_reset_gain_full: out=%0d required 1234", out_sample);
      end
      dsp_sample = -16'sd777;
      exp_v = -16'sd777;
      tick();
      total++;
      if (out_sample !== exp_v || busy !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_track: out=%0d busy=%0b required -777 0", out_sample, busy);
      end
      dsp_sample = 16'sd1000;
      tick();
   endtask

   task automatic test_fade_detail();
      int busy_cycles = 0, mc_cnt = 0;
      logic signed [15:0] neg_one;
      neg_one = -16'sd1;
      dsp_sample = 16'sd1000;
      req_mode = 2'b01;
      for (int n = 1; n <= 148; n++) begin
         int m;
         tick();
         m = n - 17;
         if (busy) busy_cycles++;
         if (mode_changed) mc_cnt++;
         if (n == 16) begin
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL fade_not_early: busy=%0b required 0", busy); end
         end
         if (m == 0) begin
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL fade_start: busy=%0b required 1", busy); end
         end
         if (m == 2) begin
            total++;
            if (out_sample !== 16'sd984) begin bad++; $display("FAIL gain63_out: out=%0d required 984", out_sample); end
         end
         if (m == 33) begin
            total++;
            if (out_sample !== 16'sd500) begin bad++; $display("FAIL gain32_out: out=%0d required 500", out_sample); end
         end
         if (m == 65) begin
            total++;
            if (mode_changed !== 1'b1 || selector !== 2'b01 || out_sample !== 16'sd0) begin
               bad++;
               $display("FAIL switch_point: mc=%0b sel=%0d out=%0d required 1 1 0", mode_changed, selector, out_sample);
            end
         end
         if (m == 66) begin
            total++;
            if (out_sample !== 16'sd0 || mode_changed !== 1'b0) begin
               bad++;
               $display("FAIL silence_hold: out=%0d mc=%0b required 0 0", out_sample, mode_changed);
            end
         end
         if (m == 97) dsp_sample = neg_one;
         if (m == 98) begin
            total++;
            if (out_sample !== neg_one) begin bad++; $display("FAIL floor_neg: out=%0d required -1", out_sample); end
            dsp_sample = 16'sd1000;
         end
         if (m == 129) begin
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL fade_end: busy=%0b required 0", busy); end
         end
         if (m == 130) begin
            total++;
            if (out_sample !== 16'sd1000) begin bad++; $display("FAIL restored_out: out=%0d required 1000", out_sample); end
         end
      end
      total++;
      if (busy_cycles != 129 || mc_cnt != 1) begin
         bad++;
         $display("FAIL fade_span: busy_cycles=%0d pulses=%0d required 129 1", busy_cycles, mc_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_glitch();
      test_hold_restart();
      test_map_11_and_requeue();
      test_reset_mid_fade();
      test_fade_detail();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
